// File: rtl/spi_sample_transmitter.sv
// SPI slave sample source: buffers samples in a small FIFO and shifts one sample
// MSB-first per chip-select frame, with spi_clock/spi_chipselect oversampled on clock.
module spi_sample_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SAMPLE_WIDTH-1:0]     sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        spi_clock,
  input  logic                        spi_chipselect,
  output logic                        spi_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_done,
  output logic                        frame_abort,
  output logic                        underrun
);

  // state | meaning
  // IDLE  | waiting for chip-select fall
  // SHIFT | frame active, one bit driven per SCK fall
  // DONE  | all bits sent, SCK ignored until chip-select rise
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_BIT    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(SAMPLE_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic                   sck_s;
  logic                   cs_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    push;
  logic                    pop;

  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]        bit_cnt;

  // Reset values match an idle bus (CS high, SCK low) so no edge is seen on release.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clock};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_chipselect};
      sck_q    <= sck_s;
      cs_q     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_fall = sck_q & ~sck_s;

  assign sample_ready = ~reset & (fifo_count < FULL_COUNT);
  assign push         = sample_valid & sample_ready;
  // Pop decision uses the pre-push count, so a same-cycle push into an empty FIFO waits.
  assign pop          = (state == IDLE) & cs_fall & (fifo_count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sample_data;
        wr_ptr      <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + ONE_COUNT;
        2'b01:   fifo_count <= fifo_count - ONE_COUNT;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      spi_data    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            if (pop) begin
              shift_reg <= mem[rd_ptr];
            end else begin
              shift_reg <= '0;
              underrun  <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // CS rise outranks a coincident SCK fall.
          if (cs_rise) begin
            frame_abort <= 1'b1;
            spi_data    <= 1'b0;
            state       <= IDLE;
          end else if (sck_fall) begin
            spi_data  <= shift_reg[SAMPLE_WIDTH-1];
            shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + ONE_BIT;
            if (bit_cnt == LAST_BIT) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_sample_transmitter.md
Name: spi_sample_transmitter

Overview:
Synthesizable SPI slave that emulates the ADC end of the sample link. It accepts 16-bit samples on a valid/ready interface and buffers them in a small FIFO. It shifts each sample out MSB-first on spi_data, one sample per chip-select frame, driven by the externally generated spi_clock/spi_chipselect from the top2 capture path. All logic runs in the single clock domain; the SPI inputs are oversampled, so it serves as both a loopback source for top2 and a bench-free stimulus generator.

Parameters:
SAMPLE_WIDTH, 16, bits per sample and per SPI frame
FIFO_DEPTH, 4, sample buffer entries (power of two, >=2)
SYNC_STAGES, 2, synchronizer flops on spi_clock and spi_chipselect (>=2)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_data  input  SAMPLE_WIDTH  sample to transmit
sample_valid  input  1  sample_data valid
sample_ready  output  1  FIFO can accept; push when valid&&ready
spi_clock  input  1  SPI clock from master, idle high or low
spi_chipselect  input  1  active-low frame select from master
spi_data  output  1  serial data to master, MSB first
fifo_count  output  clogb2(FIFO_DEPTH)+1  buffered samples
frame_done  output  1  one-cycle pulse: full sample shifted
frame_abort  output  1  one-cycle pulse: CS rose before SAMPLE_WIDTH bits
underrun  output  1  one-cycle pulse: frame started with FIFO empty

Behaviour:
- Reset (the synchronous reset input high at a rising clock edge): FIFO emptied, fifo_count=0, sample_ready=0 during reset and 1 on the first cycle after, spi_data=0, frame_done/frame_abort/underrun=0, state=IDLE, synchronizers loaded with spi_chipselect=1 and spi_clock=0. Reset mid-frame discards the frame with no pulses.
- Sync: spi_clock and spi_chipselect pass through SYNC_STAGES flops. An edge register follows the synchronizers. A CS fall, CS rise or SCK fall is detected when the synchronized value differs from the registered copy. Detection latency is SYNC_STAGES+1 clocks. The master's SCK half-period and CS setup must be >= SYNC_STAGES+2 clocks.
- FIFO: sample_ready = (fifo_count<FIFO_DEPTH). A push occurs on sample_valid&&sample_ready. When push and pop happen in the same cycle, fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- IDLE: wait for CS fall.
  - FIFO non-empty: pop the head into shift_reg.
  - FIFO empty: load shift_reg=0 and pulse underrun.
  - In both cases, bit_cnt=0 and go to SHIFT. spi_data holds its previous value.
  - A push in the same cycle as CS fall on an empty FIFO is not popped; it is kept for the next frame.
- SHIFT, on each detected SCK fall: spi_data<=shift_reg[MSB], shift_reg<<=1, bit_cnt++. After the SAMPLE_WIDTH-th fall, pulse frame_done and go to DONE.
  - The master samples on the SCK rise that follows, so bit k appears after the k-th SCK fall, matching top2 capture.
- DONE: further SCK falls are ignored and spi_data holds the LSB. CS rise returns to IDLE.
- CS rise while in SHIFT with bit_cnt<SAMPLE_WIDTH: pulse frame_abort, spi_data<=0, go to IDLE. The popped sample is lost.
- CS rise and SCK fall detected in the same cycle: CS rise wins and the SCK fall is ignored.
- CS fall while not in IDLE cannot occur, because a CS rise is detected first.
- A CS rise detected in IDLE is ignored.
- At most one of frame_done, frame_abort and underrun is asserted per cycle.

Test Plan:
- Push 0xA5C3, then run a CS-low frame with 16 SCK falls (half-period 8 clocks). Sampling spi_data at each SCK rise yields 1010010111000011; frame_done pulses once; fifo_count goes 1->0.
- Push 4 samples 0x0001,0x8000,0xFFFF,0x1234. sample_ready drops to 0 when fifo_count=4, and a 5th valid is not accepted. Four frames return the samples in order; sample_ready returns to 1 after the first pop.
- Run a frame with the FIFO empty: underrun pulses at CS fall plus 3 clocks, all 16 bits read 0, then frame_done pulses.
- Push 0xFFFF, then raise CS after 5 SCK falls: frame_abort pulses, spi_data=0, fifo_count=0. The next frame with 0x0F0F pushed reads 0x0F0F exactly.
- Assert reset for 1 cycle mid-frame after 8 bits with 2 samples queued: fifo_count=0, spi_data=0, no pulses. The following frame underruns.
- Push and pop in the same cycle with fifo_count=2: fifo_count stays 2, and FIFO order is preserved across pointer wrap over 10 frames.
